// File: rtl/lfo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lfo_pkg
//  Description : Shared types and helpers for the multi-channel LFO core.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfo_pkg;

    typedef enum logic [1:0] {
        SAW = 2'd0,
        TRI = 2'd1,
        SQR = 2'd2,
        SIN = 2'd3
    } lfo_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } lfo_state_e;

    // Channel index width; a single-channel build still carries one bit.
    function automatic int lfo_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfo_sine_rom.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lfo_sine_rom
//  Description : Registered quarter-wave sine table built at elaboration.
//                addr MSB selects the negative half; data is the centred code.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfo_sine_rom #(
    parameter int OUT_W  = 12,
    parameter int LUT_AW = 8
) (
    input  logic              clk,
    input  logic [LUT_AW:0]   addr,
    output logic [OUT_W-1:0]  data
);

    localparam int               c_depth = 2 ** LUT_AW;
    localparam real              c_amp   = real'((2 ** (OUT_W - 1)) - 1);
    localparam real              c_pi    = 3.14159265358979323846;
    localparam logic [OUT_W-1:0] c_mid   = OUT_W'(2 ** (OUT_W - 1));

    logic [OUT_W-2:0] w_rom [c_depth];
    logic [OUT_W-1:0] w_mag;

    for (genvar k = 0; k < c_depth; k++) begin : g_rom
        localparam int c_val = $rtoi($floor(c_amp *
            $sin(c_pi / 2.0 * (real'(k) + 0.5) / real'(c_depth)) + 0.5));
        assign w_rom[k] = (OUT_W - 1)'(c_val);
    end

    assign w_mag = {1'b0, w_rom[addr[LUT_AW-1:0]]};

    always_ff @(posedge clk) begin
        data <= addr[LUT_AW] ? (c_mid - w_mag) : (c_mid + w_mag);
    end

endmodule
`default_nettype wire

// File: rtl/lfo_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lfo_engine
//  Description : NCH-channel LFO: per-channel phase accumulators shaped into
//                saw/tri/square/sine and streamed over valid/ready.
//                Optional sine table enabled by macro LFO_SINE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfo_engine
    import lfo_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 12,
    parameter int LUT_AW  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      cfg_we,
    input  logic [lfo_ch_w(NCH)-1:0]  cfg_ch,
    input  logic [PHASE_W-1:0]        cfg_inc,
    input  logic [1:0]                cfg_mode,
    input  logic                      cfg_sync,
    input  logic                      ovr_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [lfo_ch_w(NCH)-1:0]  out_ch,
    output logic [OUT_W-1:0]          out_data,
    output logic                      overrun
);

    localparam int                c_ch_w    = lfo_ch_w(NCH);
    localparam logic [c_ch_w-1:0] c_last_ch = c_ch_w'(NCH - 1);

    if ((NCH < 1) || (NCH > 8) || (PHASE_W < OUT_W + 2) || (LUT_AW > PHASE_W - 2))
    begin : g_param_check
        $error("lfo_engine: illegal parameter combination");
    end

    logic [PHASE_W-1:0] r_phase [NCH];
    logic [PHASE_W-1:0] r_inc   [NCH];
    lfo_mode_e          r_mode  [NCH];
    lfo_state_e         r_state;
    logic [c_ch_w-1:0]  r_ch;
    logic [OUT_W-1:0]   r_shape;
    logic               r_valid;
    logic               r_overrun;
    logic               w_cfg_hit;

    assign w_cfg_hit = cfg_we && ({1'b0, cfg_ch} < (c_ch_w + 1)'(NCH));

    // Sync beats a coincident tick; accumulation never waits on the FSM.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic w_sel;
        assign w_sel = w_cfg_hit && (cfg_ch == c_ch_w'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_phase[i] <= '0;
                r_inc[i]   <= '0;
                r_mode[i]  <= SAW;
            end else begin
                if (w_sel && cfg_sync) begin
                    r_phase[i] <= '0;
                end else if (tick) begin
                    r_phase[i] <= r_phase[i] + r_inc[i];
                end
                if (w_sel) begin
                    r_inc[i]  <= cfg_inc;
                    r_mode[i] <= lfo_mode_e'(cfg_mode);
                end
            end
        end
    end

    lfo_mode_e        w_mode;
    logic             w_msb;
    logic [OUT_W-1:0] w_t;
    logic [OUT_W-1:0] w_shape;

    assign w_mode = r_mode[r_ch];
    assign w_msb  = r_phase[r_ch][PHASE_W-1];
    assign w_t    = r_phase[r_ch][PHASE_W-2 -: OUT_W];

    always_comb begin
        w_shape = r_phase[r_ch][PHASE_W-1 -: OUT_W];
        case (w_mode)
            TRI, SIN: w_shape = w_msb ? ~w_t : w_t;
            SQR:      w_shape = w_msb ? '0 : '1;
            default:  w_shape = r_phase[r_ch][PHASE_W-1 -: OUT_W];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_shape   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (tick) begin
                        r_ch    <= '0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_shape <= w_shape;
                    r_valid <= 1'b1;
                    r_state <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (r_ch == c_last_ch) begin
                            r_state <= IDLE;
                        end else begin
                            r_ch    <= r_ch + c_ch_w'(1);
                            r_state <= LOAD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LFO_SINE_EN
    // The table address is frozen outside LOAD so the registered ROM output
    // stays stable while a sample waits in PRESENT.
    logic [LUT_AW-1:0] w_lut_a;
    logic [LUT_AW:0]   w_rom_addr;
    logic [LUT_AW:0]   r_rom_addr;
    logic [OUT_W-1:0]  w_rom_data;
    logic              r_sin_sel;

    assign w_lut_a    = r_phase[r_ch][PHASE_W-3 -: LUT_AW] ^ {LUT_AW{r_phase[r_ch][PHASE_W-2]}};
    assign w_rom_addr = (r_state == LOAD) ? {w_msb, w_lut_a} : r_rom_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_sin_sel  <= 1'b0;
        end else begin
            r_rom_addr <= w_rom_addr;
            if (r_state == LOAD) begin
                r_sin_sel <= (w_mode == SIN);
            end
        end
    end

    lfo_sine_rom #(
        .OUT_W  (OUT_W),
        .LUT_AW (LUT_AW)
    ) u_sine_rom (
        .clk  (clk),
        .addr (w_rom_addr),
        .data (w_rom_data)
    );

    assign out_data = r_sin_sel ? w_rom_data : r_shape;
`else
    assign out_data = r_shape;
`endif

    assign out_valid = r_valid;
    assign out_ch    = r_ch;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lfo_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lfo_engine
//  Description : Self-checking bench for lfo_engine against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfo_engine;

    localparam int NCH     = 3;
    localparam int PHASE_W = 24;
    localparam int OUT_W   = 12;
    localparam int LUT_AW  = 8;
    localparam int CH_W    = 2;
    localparam int unsigned c_mask  = (1 << OUT_W) - 1;
    localparam int unsigned c_pmask = (1 << PHASE_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [PHASE_W-1:0] cfg_inc = '0;
    logic [1:0]        cfg_mode = '0;
    logic              cfg_sync = 1'b0;
    logic              ovr_clr = 1'b0;
    logic              out_ready = 1'b1;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [OUT_W-1:0]  out_data;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;

    lfo_engine #(
        .NCH (NCH), .PHASE_W (PHASE_W), .OUT_W (OUT_W), .LUT_AW (LUT_AW)
    ) dut (
        .clk (clk), .rst (rst), .tick (tick), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
        .cfg_inc (cfg_inc), .cfg_mode (cfg_mode), .cfg_sync (cfg_sync),
        .ovr_clr (ovr_clr), .out_valid (out_valid), .out_ready (out_ready),
        .out_ch (out_ch), .out_data (out_data), .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: phases per channel plus a frame slot counter
    // (0 idle, odd = channel being loaded, even = channel on the bus).
    int unsigned m_phase [NCH];
    int unsigned m_inc   [NCH];
    int          m_mode  [NCH];
    int          m_slot;
    int          m_outch;
    int unsigned m_data;
    bit          m_ovr;

    function automatic int unsigned shape(input int unsigned p, input int md);
        int unsigned msb, t, tri_v;
`ifdef LFO_SINE_EN
        int unsigned a, rom, amax;
        real amp, ang;
`endif
        msb   = (p >> (PHASE_W - 1)) & 1;
        t     = (p >> (PHASE_W - 1 - OUT_W)) & c_mask;
        tri_v = (msb != 0) ? (c_mask - t) : t;
        case (md)
            0: return (p >> (PHASE_W - OUT_W)) & c_mask;
            1: return tri_v;
            2: return (msb != 0) ? 0 : c_mask;
            default: begin
`ifdef LFO_SINE_EN
                amax = (1 << LUT_AW) - 1;
                a    = (p >> (PHASE_W - 2 - LUT_AW)) & amax;
                if (((p >> (PHASE_W - 2)) & 1) != 0) a = amax - a;
                amp  = real'((1 << (OUT_W - 1)) - 1);
                ang  = 3.14159265358979323846 / 2.0 * (real'(a) + 0.5) / real'(1 << LUT_AW);
                rom  = $rtoi($floor(amp * $sin(ang) + 0.5));
                return (msb != 0) ? ((1 << (OUT_W - 1)) - rom) : ((1 << (OUT_W - 1)) + rom);
`else
                return tri_v;
`endif
            end
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_phase[i] = 0;
            m_inc[i]   = 0;
            m_mode[i]  = 0;
        end
        m_slot  = 0;
        m_outch = 0;
        m_data  = 0;
        m_ovr   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        if (tick && m_slot != 0) m_ovr = 1'b1;
        else if (ovr_clr)        m_ovr = 1'b0;

        if (m_slot == 0) begin
            if (tick) m_slot = 1;
        end else if (m_slot % 2 == 1) begin
            m_data = shape(m_phase[(m_slot - 1) / 2], m_mode[(m_slot - 1) / 2]);
            m_slot++;
        end else if (out_ready) begin
            m_slot = (m_slot == 2 * NCH) ? 0 : m_slot + 1;
        end
        if (m_slot != 0) m_outch = (m_slot - 1) / 2;

        for (int i = 0; i < NCH; i++) begin
            if (cfg_we && int'(cfg_ch) == i && cfg_sync) m_phase[i] = 0;
            else if (tick) m_phase[i] = (m_phase[i] + m_inc[i]) & c_pmask;
            if (cfg_we && int'(cfg_ch) == i) begin
                m_inc[i]  = int'(cfg_inc);
                m_mode[i] = int'(cfg_mode);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/valid"},   32'(out_valid), 32'((m_slot != 0) && (m_slot % 2 == 0)));
        chk({tag, "/ch"},      32'(out_ch),    32'(m_outch));
        chk({tag, "/data"},    32'(out_data),  m_data);
        chk({tag, "/overrun"}, 32'(overrun),   32'(m_ovr));
    endtask

    task automatic cycle(input string tag);
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic write_cfg(input int ch, input int unsigned inc, input int md, input bit sync);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_inc  = PHASE_W'(inc);
        cfg_mode = 2'(md);
        cfg_sync = sync;
        cycle("cfg");
        cfg_we   = 1'b0;
        cfg_sync = 1'b0;
    endtask

    task automatic tick_pulse(input string tag);
        tick = 1'b1;
        cycle(tag);
        tick = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        repeat (2 * NCH + 2) cycle(tag);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) cycle("reset");
        rst = 1'b0;
        check_outputs("reset_rel");

        // Saw on ch0, first frame latency and contents.
        write_cfg(0, 32'h100000, 0, 1'b0);
        tick_pulse("t1_load");
        chk("t1_load_valid", 32'(out_valid), 32'd0);
        cycle("t1_p0");
        chk("t1_data0", 32'(out_data), 32'h100);
        cycle("t1_l1");
        cycle("t1_p1");
        chk("t1_data1", 32'(out_data), 32'h000);
        drain("t1_drain");

        // Triangle on ch1 over four ticks.
        write_cfg(1, 32'h400000, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick_pulse("t2_tick");
            drain("t2_drain");
        end

        // Backpressure, overrun, clear.
        out_ready = 1'b0;
        tick_pulse("t3_tick");
        cycle("t3_present");
        chk("t3_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick = (k == 5);
            cycle("t3_hold");
        end
        tick = 1'b0;
        chk("t3_overrun", 32'(overrun), 32'd1);
        drain("t3_drain");
        ovr_clr = 1'b1;
        cycle("t3_clr");
        ovr_clr = 1'b0;

        // Sync coincident with a tick.
        tick = 1'b1;
        write_cfg(0, 32'h100000, 0, 1'b1);
        tick = 1'b0;
        cycle("t4_p0");
        chk("t4_data0", 32'(out_data), 32'h000);
        drain("t4_drain");

        // Mode 3 at quarter and three-quarter phase.
        write_cfg(2, 32'h400000, 3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick_pulse("t5_tick");
            repeat (5) cycle("t5_walk");
            if (k == 0) begin
`ifdef LFO_SINE_EN
                chk("t5_sine_top", 32'(out_data >= 12'hFFE), 32'd1);
`else
                chk("t5_tri_top", 32'(out_data), 32'h800);
`endif
            end else if (k == 2) begin
`ifdef LFO_SINE_EN
                chk("t5_sine_bot", 32'(out_data <= 12'h001), 32'd1);
`else
                chk("t5_tri_bot", 32'(out_data), 32'h7FF);
`endif
            end
            drain("t5_drain");
        end

        // Out-of-range channel write is ignored.
        write_cfg(NCH, 32'hABCDEF, 2, 1'b1);
        tick_pulse("t6_tick");
        drain("t6_drain");

        // Asynchronous reset while a sample is presented.
        out_ready = 1'b0;
        tick_pulse("t6_tick2");
        cycle("t6_present");
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("t6_after_rst");
        tick_pulse("t6_tick3");
        drain("t6_zero");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            tick      = ($urandom_range(15) == 0);
            out_ready = ($urandom_range(3) != 0);
            cfg_we    = ($urandom_range(19) == 0);
            cfg_ch    = CH_W'($urandom_range(3));
            cfg_inc   = PHASE_W'($urandom);
            cfg_mode  = 2'($urandom_range(3));
            cfg_sync  = ($urandom_range(3) == 0);
            ovr_clr   = ($urandom_range(31) == 0);
            cycle("rand");
        end
        tick = 1'b0;
        cfg_we = 1'b0;
        ovr_clr = 1'b0;
        drain("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
